// File: rtl/md_issue_ctrl_if.sv
// rtl/md_issue_ctrl_if.sv - E-stage mult/div issue bus between pipeline and issue controller
interface md_issue_ctrl_if;
    logic       op_valid_e;
    logic [3:0] md_op_e;
    logic [3:0] md_op_d;
    logic       md_busy;
    logic       int_req;
    logic       md_start;
    logic [2:0] md_sel;
    logic       md_remthi;
    logic       md_remtlo;
    logic       stall_d;
    logic [1:0] md_state;

    modport master (
        output op_valid_e, md_op_e, md_op_d, md_busy, int_req,
        input  md_start, md_sel, md_remthi, md_remtlo, stall_d, md_state
    );

    modport slave (
        input  op_valid_e, md_op_e, md_op_d, md_busy, int_req,
        output md_start, md_sel, md_remthi, md_remtlo, stall_d, md_state
    );
endinterface

// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - mult/div issue, latency shadow, D-stall and HI/LO rollback control
module md_issue_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic           clk,
    input  logic           reset,
    md_issue_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    logic [1:0] state;
    logic [3:0] cnt;
    logic       mt_hi_q;
    logic       mt_lo_q;
    logic       iss;
    logic       is_mul;
    logic       is_div;
    logic       start;
    logic [3:0] op_m1;

    always_comb begin
        iss    = bus.op_valid_e & ~bus.int_req & (bus.md_op_e != 4'd0);
        is_mul = (bus.md_op_e == 4'd1) | (bus.md_op_e == 4'd2);
        is_div = (bus.md_op_e == 4'd3) | (bus.md_op_e == 4'd4);
        start  = iss & (is_mul | is_div);
        op_m1  = bus.md_op_e - 4'd1;
    end

    // sel 4/5 make the unit write HI/LO, so they only appear on a real issue
    assign bus.md_start  = start;
    assign bus.md_sel    = (iss && bus.md_op_e <= 4'd6) ? op_m1[2:0] : 3'd7;
    assign bus.md_remthi = mt_hi_q & bus.int_req;
    assign bus.md_remtlo = mt_lo_q & bus.int_req;
    assign bus.stall_d   = (bus.md_op_d != 4'd0)
                         & ((state != S_IDLE) | start | bus.md_busy)
                         & ~bus.int_req;
    assign bus.md_state  = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            mt_hi_q <= 1'b0;
            mt_lo_q <= 1'b0;
        end else begin
            mt_hi_q <= iss & (bus.md_op_e == 4'd5);
            mt_lo_q <= iss & (bus.md_op_e == 4'd6);
            if (bus.int_req) begin
                state <= S_IDLE;
                cnt   <= 4'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && is_mul) begin
                            state <= S_MUL;
                            cnt   <= 4'(MUL_LAT);
                        end else if (start && is_div) begin
                            state <= S_DIV;
                            cnt   <= 4'(DIV_LAT);
                        end
                    end
                    S_MUL, S_DIV: begin
                        if (cnt == 4'd1) state <= S_IDLE;
                        cnt <= cnt - 4'd1;
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= 4'd0;
                    end
                endcase
            end
        end
    end

    // D is stalled while busy, so a second start can only come from a broken pipeline
    assert property (@(posedge clk) disable iff (!reset) !(start && state != S_IDLE));
endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb/tb_md_issue_ctrl.sv - self-checking bench for md_issue_ctrl with a behavioural mult/div unit
module tb_md_issue_ctrl;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    md_issue_ctrl_if bus();

    md_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cyc = 0;
    int kind = 0;
    int last_hi = -10;
    int last_lo = -10;
    int ucnt = 0;
    logic [31:0] hi = '0, lo = '0, shi = '0, slo = '0, rhi = '0, rlo = '0;
    logic [31:0] opa = '0, opb = 32'd1;
    logic last_stall = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [3:0] ope,
                        input logic [3:0] opd, input logic ir);
        logic inf, iss, e_start, e_stall, e_rh, e_rl;
        logic [2:0] e_sel;
        logic [1:0] e_state;
        logic o_start, o_rh, o_rl;
        logic [2:0] o_sel;
        longint sp;
        longint unsigned up;
        reset = rst;
        bus.op_valid_e = v;
        bus.md_op_e = ope;
        bus.md_op_d = opd;
        bus.int_req = ir;
        @(negedge clk);
        inf     = cyc < done_cyc;
        iss     = v && !ir && ope != 4'd0;
        e_start = iss && ope >= 4'd1 && ope <= 4'd4;
        e_sel   = (iss && ope <= 4'd6) ? 3'(int'(ope) - 1) : 3'd7;
        e_state = inf ? 2'(kind) : 2'd0;
        e_stall = opd != 4'd0 && (inf || e_start || bus.md_busy) && !ir;
        e_rh    = ir && last_hi == cyc - 1;
        e_rl    = ir && last_lo == cyc - 1;
        check("md_start", 32'(bus.md_start), 32'(e_start));
        check("md_sel", 32'(bus.md_sel), 32'(e_sel));
        check("md_remthi", 32'(bus.md_remthi), 32'(e_rh));
        check("md_remtlo", 32'(bus.md_remtlo), 32'(e_rl));
        check("stall_d", 32'(bus.stall_d), 32'(e_stall));
        check("md_state", 32'(bus.md_state), 32'(e_state));
        last_stall = bus.stall_d;
        o_start = bus.md_start;
        o_sel = bus.md_sel;
        o_rh = bus.md_remthi;
        o_rl = bus.md_remtlo;
        @(posedge clk);
        if (!rst) begin
            done_cyc = cyc + 1;
            last_hi = -10;
            last_lo = -10;
            ucnt = 0;
        end else begin
            if (ir) done_cyc = cyc + 1;
            else if (e_start && !inf) begin
                done_cyc = cyc + 1 + ((ope <= 4'd2) ? MUL_LAT : DIV_LAT);
                kind = (ope <= 4'd2) ? 1 : 2;
            end
            if (iss && ope == 4'd5) last_hi = cyc;
            if (iss && ope == 4'd6) last_lo = cyc;
            if (ir) ucnt = 0;
            else if (ucnt != 0) begin
                ucnt--;
                if (ucnt == 0) begin
                    hi = rhi;
                    lo = rlo;
                end
            end
            if (o_start) begin
                ucnt = (o_sel <= 3'd1) ? MUL_LAT : DIV_LAT;
                case (o_sel)
                    3'd0: begin sp = longint'($signed(opa)) * longint'($signed(opb)); {rhi, rlo} = sp; end
                    3'd1: begin up = {32'd0, opa} * {32'd0, opb}; {rhi, rlo} = up; end
                    3'd2: begin rlo = $signed(opa) / $signed(opb); rhi = $signed(opa) % $signed(opb); end
                    default: begin rlo = opa / opb; rhi = opa % opb; end
                endcase
            end
            if (o_sel == 3'd4) begin shi = hi; hi = opa; end
            if (o_sel == 3'd5) begin slo = lo; lo = opa; end
            if (o_rh) hi = shi;
            if (o_rl) lo = slo;
        end
        cyc++;
        #1 bus.md_busy = (ucnt != 0);
    endtask

    task automatic drain(input logic [3:0] opd, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!last_stall) break;
            n++;
            step(1'b1, 1'b0, 4'd0, opd, 1'b0);
        end
    endtask

    initial begin
        int n;
        logic rst, v, ir;
        logic [3:0] ope, opd;
        bus.op_valid_e = 1'b0;
        bus.md_op_e = 4'd0;
        bus.md_op_d = 4'd0;
        bus.md_busy = 1'b0;
        bus.int_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step(1'b0, 1'b0, 4'd0, 4'd7, 1'b0);
        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);

        opa = 32'd7; opb = 32'hFFFF_FFFD;
        step(1'b1, 1'b1, 4'd1, 4'd7, 1'b0);
        drain(4'd7, n);
        check("mul_stall_cycles", 32'(n), 32'(1 + MUL_LAT));
        check("mul_hi", hi, 32'hFFFF_FFFF);
        check("mul_lo", lo, 32'hFFFF_FFEB);

        opa = 32'd100; opb = 32'd7;
        step(1'b1, 1'b1, 4'd4, 4'd8, 1'b0);
        drain(4'd8, n);
        check("divu_stall_cycles", 32'(n), 32'(1 + DIV_LAT));
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        opa = 32'd50; opb = 32'd3;
        step(1'b1, 1'b1, 4'd3, 4'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 4'd7, 1'b1);
        repeat (12) step(1'b1, 1'b0, 4'd0, 4'd7, 1'b0);
        check("div_cancel_hi", hi, 32'd2);
        check("div_cancel_lo", lo, 32'd14);

        opa = 32'h1234;
        step(1'b1, 1'b1, 4'd5, 4'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        check("mthi_hi", hi, 32'h1234);
        opa = 32'hDEAD;
        step(1'b1, 1'b1, 4'd5, 4'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        check("mthi_rollback_hi", hi, 32'h1234);
        step(1'b1, 1'b1, 4'd5, 4'd0, 1'b0);
        repeat (2) step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        check("mthi_keep_hi", hi, 32'hDEAD);
        opa = 32'hAAAA;
        step(1'b1, 1'b1, 4'd5, 4'd0, 1'b0);
        opa = 32'hBBBB;
        step(1'b1, 1'b1, 4'd6, 4'd0, 1'b1);
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        check("mthi_mtlo_int_hi", hi, 32'hDEAD);
        check("mthi_mtlo_int_lo", lo, 32'd14);

        opa = 32'h5555;
        step(1'b1, 1'b0, 4'd5, 4'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        check("bubble_hi", hi, 32'hDEAD);
        opa = 32'd3; opb = 32'd4;
        step(1'b1, 1'b1, 4'd1, 4'd0, 1'b0);
        repeat (3) step(1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
        repeat (4) step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);

        opa = 32'd99; opb = 32'd5;
        step(1'b1, 1'b1, 4'd3, 4'd0, 1'b0);
        repeat (4) step(1'b1, 1'b0, 4'd0, 4'd7, 1'b0);
        step(1'b0, 1'b0, 4'd0, 4'd7, 1'b0);
        step(1'b1, 1'b0, 4'd0, 4'd7, 1'b0);
        check("reset_mid_div_stall", 32'(last_stall), 32'd0);

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom % 60) != 0;
            v   = ($urandom % 4) != 0;
            ir  = ($urandom % 10) == 0;
            opd = 4'($urandom % 9);
            if (cyc < done_cyc) ope = v ? 4'd0 : 4'($urandom % 9);
            else ope = 4'($urandom % 9);
            opa = $urandom;
            opb = $urandom | 32'd1;
            step(rst, v, ope, opd, ir);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
